// File: rtl/simplerisc_hazard_ctrl_if.sv
// Pipeline-side signals of the SimpleRisc interlock/flush controller.
// The master drives OF decode info and branch resolution; the slave returns control and statistics.
interface simplerisc_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic             of_valid;
  logic             of_src1_en;
  logic [3:0]       of_src1;
  logic             of_src2_en;
  logic [3:0]       of_src2;
  logic             of_dst_en;
  logic [3:0]       of_dst;
  logic             of_is_load;
  logic             br_taken;
  logic             stall;
  logic             flush_of;
  logic             flush_ex;
  logic             sb_busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output of_valid, of_src1_en, of_src1, of_src2_en, of_src2,
           of_dst_en, of_dst, of_is_load, br_taken,
    input  stall, flush_of, flush_ex, sb_busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  of_valid, of_src1_en, of_src1, of_src2_en, of_src2,
           of_dst_en, of_dst, of_is_load, br_taken,
    output stall, flush_of, flush_ex, sb_busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/simplerisc_hazard_ctrl.sv
// RAW interlock and taken-branch squash control for the 5-stage SimpleRisc pipeline.
// A 3-deep destination scoreboard tracks instructions in EX, MA and RW.
module simplerisc_hazard_ctrl #(
  parameter int FWD   = 0,
  parameter int CNT_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  simplerisc_hazard_ctrl_if.slave hif
);
  typedef struct packed {
    logic       v;
    logic [3:0] dst;
    logic       ld;
  } sb_ent_t;

  sb_ent_t [2:0]    ent;
  logic [2:0]       hit1, hit2;
  logic             haz, issue;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  for (genvar i = 0; i < 3; i++) begin : g_hit
    assign hit1[i] = hif.of_src1_en & ent[i].v & (ent[i].dst == hif.of_src1);
    assign hit2[i] = hif.of_src2_en & ent[i].v & (ent[i].dst == hif.of_src2);
  end

  // With forwarding only a load sitting in EX cannot supply its result in time.
  if (FWD != 0) begin : g_fwd
    assign haz = (hit1[0] | hit2[0]) & ent[0].ld;
  end else begin : g_nofwd
    assign haz = |{hit1, hit2};
  end

  assign hif.stall     = !rst & hif.of_valid & haz & !hif.br_taken;
  assign hif.flush_of  = !rst & hif.br_taken;
  assign hif.flush_ex  = !rst & hif.br_taken;
  assign hif.sb_busy   = ent[0].v | ent[1].v | ent[2].v;
  assign hif.stall_cnt = stall_cnt_q;
  assign hif.flush_cnt = flush_cnt_q;
  assign issue         = hif.of_valid & !hif.stall & !hif.br_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      ent         <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ent[0] <= issue ? sb_ent_t'({hif.of_dst_en, hif.of_dst, hif.of_is_load}) : sb_ent_t'('0);
      // The wrong-path EX instruction dies; the branch itself moves on to RW.
      ent[1] <= hif.br_taken ? sb_ent_t'('0) : ent[0];
      ent[2] <= ent[1];
      if (hif.stall && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (hif.br_taken && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_simplerisc_hazard_ctrl.sv
// Bench: two controllers (no forwarding, 4-bit counters / forwarding, 16-bit counters) on shared stimulus,
// checked every cycle against an issue-history model plus literal expectations.
module tb_simplerisc_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       v, s1en, s2en, den, ld, br;
  logic [3:0] s1, s2, d;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rst = -1;

  // Model: per-cycle issue history, squash marks and counters, per DUT.
  bit          mv  [2][4096];
  bit [3:0]    md  [2][4096];
  bit          mld [2][4096];
  bit          msq [2][4096];
  int unsigned mscnt [2];
  int unsigned mfcnt [2];

  always #5 clk = ~clk;

  simplerisc_hazard_ctrl_if #(.CNT_W(4))  if0 ();
  simplerisc_hazard_ctrl_if #(.CNT_W(16)) if1 ();

  assign if0.of_valid = v;    assign if1.of_valid = v;
  assign if0.of_src1_en = s1en; assign if1.of_src1_en = s1en;
  assign if0.of_src1 = s1;    assign if1.of_src1 = s1;
  assign if0.of_src2_en = s2en; assign if1.of_src2_en = s2en;
  assign if0.of_src2 = s2;    assign if1.of_src2 = s2;
  assign if0.of_dst_en = den; assign if1.of_dst_en = den;
  assign if0.of_dst = d;      assign if1.of_dst = d;
  assign if0.of_is_load = ld; assign if1.of_is_load = ld;
  assign if0.br_taken = br;   assign if1.br_taken = br;

  simplerisc_hazard_ctrl #(.FWD(0), .CNT_W(4))  dut0 (.clk(clk), .rst(rst), .hif(if0.slave));
  simplerisc_hazard_ctrl #(.FWD(1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .hif(if1.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Hazard from the rules: a pending writer issued 1..3 cycles ago (no forwarding),
  // or a load issued exactly 1 cycle ago (forwarding).
  function automatic bit mhaz(int u);
    for (int k = cyc - 3; k < cyc; k++) begin
      if (k >= 0 && k > last_rst && mv[u][k] && !msq[u][k]) begin
        bit m;
        m = (s1en && md[u][k] == s1) || (s2en && md[u][k] == s2);
        if (u == 0 && m) return 1'b1;
        if (u == 1 && m && k == cyc - 1 && mld[u][k]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic bit mbusy(int u);
    for (int k = cyc - 3; k < cyc; k++)
      if (k >= 0 && k > last_rst && mv[u][k] && !msq[u][k]) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      bit es, ef, eb, iss;
      int unsigned mx;
      logic        a_st, a_fo, a_fe, a_bz;
      logic [31:0] a_sc, a_fc;
      a_st = (u == 0) ? if0.stall    : if1.stall;
      a_fo = (u == 0) ? if0.flush_of : if1.flush_of;
      a_fe = (u == 0) ? if0.flush_ex : if1.flush_ex;
      a_bz = (u == 0) ? if0.sb_busy  : if1.sb_busy;
      a_sc = (u == 0) ? 32'(if0.stall_cnt) : 32'(if1.stall_cnt);
      a_fc = (u == 0) ? 32'(if0.flush_cnt) : 32'(if1.flush_cnt);
      mx   = (u == 0) ? 32'd15 : 32'd65535;
      es   = !rst && v && mhaz(u) && !br;
      ef   = !rst && br;
      eb   = mbusy(u);
      chk($sformatf("stall%0d", u),     32'(a_st), 32'(es));
      chk($sformatf("flush_of%0d", u),  32'(a_fo), 32'(ef));
      chk($sformatf("flush_ex%0d", u),  32'(a_fe), 32'(ef));
      chk($sformatf("sb_busy%0d", u),   32'(a_bz), 32'(eb));
      chk($sformatf("stall_cnt%0d", u), a_sc, mscnt[u]);
      chk($sformatf("flush_cnt%0d", u), a_fc, mfcnt[u]);
      iss = v && !es && !br;
      mv[u][cyc]  = iss && den;
      md[u][cyc]  = d;
      mld[u][cyc] = ld;
      if (ef && cyc > 0) msq[u][cyc-1] = 1'b1;
      if (rst) begin
        mscnt[u] = 0;
        mfcnt[u] = 0;
      end else begin
        if (es && mscnt[u] < mx) mscnt[u]++;
        if (br && mfcnt[u] < mx) mfcnt[u]++;
      end
    end
    if (rst) last_rst = cyc;
    cyc++;
  end

  task automatic set(input bit iv, is1en, input bit [3:0] is1, input bit is2en, input bit [3:0] is2,
                     input bit iden, input bit [3:0] id, input bit ild, ibr, ir);
    v = iv; s1en = is1en; s1 = is1; s2en = is2en; s2 = is2;
    den = iden; d = id; ld = ild; br = ibr; rst = ir;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input bit iv, is1en, input bit [3:0] is1, input bit is2en, input bit [3:0] is2,
                    input bit iden, input bit [3:0] id, input bit ild, ibr, ir);
    set(iv, is1en, is1, is2en, is2, iden, id, ild, ibr, ir);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick(); tick();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("reset_stall", 32'(if0.stall), 0);
    chk("reset_busy", 32'(if0.sb_busy), 0);
    chk("reset_cnt", 32'(if0.stall_cnt), 0);
    tick();

    // RAW on r3 without forwarding: three stall cycles then issue
    op(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    set(1, 1, 3, 0, 0, 1, 8, 0, 0, 0);
    #2 chk("raw_stall_c1", 32'(if0.stall), 1);
    tick(); tick();
    #2 chk("raw_stall_c3", 32'(if0.stall), 1);
    tick();
    #2 chk("raw_issue_c4", 32'(if0.stall), 0);
    tick();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    #2 chk("raw_busy_tail", 32'(if0.sb_busy), 1);
    tick();
    #2 chk("raw_busy_drop", 32'(if0.sb_busy), 0);
    chk("raw_stall_cnt", 32'(if0.stall_cnt), 3);
    chk("fwd_alu_no_stall_cnt", 32'(if1.stall_cnt), 0);
    tick();

    // Load-use with forwarding, then the same with an ALU producer
    op(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    op(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
    set(1, 0, 0, 1, 5, 0, 0, 0, 0, 0);
    #2 chk("ldu_stall", 32'(if1.stall), 1);
    tick();
    #2 chk("ldu_issue", 32'(if1.stall), 0);
    tick();
    idle(3);
    chk("ldu_stall_cnt", 32'(if1.stall_cnt), 1);
    op(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    set(1, 0, 0, 1, 5, 0, 0, 0, 0, 0);
    #2 chk("alu_fwd_nostall", 32'(if1.stall), 0);
    tick();
    idle(3);
    chk("alu_stall_cnt", 32'(if1.stall_cnt), 1);

    // call, filler, ret resolving with br_taken: call kept in RW, filler squashed
    op(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    op(1, 0, 0, 0, 0, 1, 15, 0, 0, 0);
    op(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set(1, 1, 15, 0, 0, 0, 0, 0, 1, 0);
    #2 chk("br_no_stall", 32'(if0.stall), 0);
    chk("br_flush_of", 32'(if0.flush_of), 1);
    chk("br_flush_ex", 32'(if0.flush_ex), 1);
    tick();
    set(1, 1, 15, 0, 0, 1, 2, 0, 0, 0);
    #2 chk("br_call_in_rw", 32'(if0.stall), 1);
    chk("br_flush_cnt", 32'(if0.flush_cnt), 1);
    tick();
    #2 chk("br_call_retired", 32'(if0.stall), 0);
    tick();
    idle(1);
    // back-to-back taken branches
    op(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    op(1, 0, 0, 0, 0, 1, 10, 0, 0, 0);
    op(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    op(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    op(1, 1, 9, 1, 10, 0, 0, 0, 0, 0);
    op(1, 1, 9, 1, 10, 0, 0, 0, 0, 0);
    idle(3);
    chk("b2b_flush_cnt", 32'(if0.flush_cnt), 3);

    // Independent stream r1,r2,r4 reading r6,r7; then unused fields matching pending dst
    op(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    op(1, 1, 6, 1, 7, 1, 1, 0, 0, 0);
    op(1, 1, 6, 1, 7, 1, 2, 0, 0, 0);
    op(1, 1, 6, 1, 7, 1, 4, 0, 0, 0);
    set(1, 0, 4, 0, 2, 0, 0, 0, 0, 0);
    #2 chk("srcen_gating", 32'(if0.stall), 0);
    tick();
    idle(4);
    chk("indep_stall_cnt", 32'(if0.stall_cnt), 0);

    // Self-dependent load held for 30 cycles: 4-bit counter saturates
    op(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    set(1, 1, 3, 0, 0, 1, 3, 1, 0, 0);
    for (int i = 0; i < 30; i++) tick();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 chk("sat_stall_cnt", 32'(if0.stall_cnt), 15);
    tick();
    idle(3);

    // Reset in the 2nd cycle of a 3-cycle stall
    op(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    op(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    set(1, 1, 3, 0, 0, 1, 8, 0, 0, 0);
    #2 chk("pre_rst_stall", 32'(if0.stall), 1);
    tick();
    set(1, 1, 3, 0, 0, 1, 8, 0, 0, 1);
    #2 chk("rst_kills_stall", 32'(if0.stall), 0);
    tick();
    set(1, 1, 3, 0, 0, 1, 8, 0, 0, 0);
    #2 chk("post_rst_busy", 32'(if0.sb_busy), 0);
    chk("post_rst_cnt", 32'(if0.stall_cnt), 0);
    chk("post_rst_issue", 32'(if0.stall), 0);
    tick();
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
